// File: rtl/mem_reader.sv
// Reads length bytes from memory starting at base_addr and streams them out one byte per ISSUE/CAPTURE/STREAM pass.
// First out_valid two cycles after an accepted start; out_ready low holds the byte in STREAM with no loss.
module mem_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  program_mode,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_oe,
  input  logic [DATA_WIDTH-1:0] data_bus,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    STREAM,
    DONE
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH:0]   cnt;
  logic [ADDR_WIDTH:0]   cnt_dec;

  assign cnt_dec = cnt - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_reg <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            addr_reg <= base_addr;
            cnt      <= length;
          end
        end
        CAPTURE: out_data <= data_bus;
        STREAM: begin
          // Address wraps naturally at 2^ADDR_WIDTH.
          if (out_ready) begin
            cnt      <= cnt_dec;
            addr_reg <= addr_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    program_mode = 1'b1;
    busy         = 1'b1;
    mem_oe       = 1'b0;
    out_valid    = 1'b0;
    done         = 1'b0;
    mem_addr     = addr_reg;
    case (state)
      IDLE: begin
        program_mode = 1'b0;
        busy         = 1'b0;
        if (start) state_nxt = (length != '0) ? ISSUE : DONE;
      end
      ISSUE: begin
        mem_oe    = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = STREAM;
      STREAM: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = (cnt_dec != '0) ? ISSUE : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bus width (matches `DATA_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width (matches `ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a dump; sampled only in IDLE.
REQ-006 SHALL have port base_addr  input  ADDR_WIDTH  first address to read; latched on accepted start.
REQ-007 SHALL have port length  input  ADDR_WIDTH+1  number of bytes to read (0 to 2^ADDR_WIDTH); latched on accepted start.
REQ-008 SHALL have port program  output  1  holds CPU in program mode, which releases the memory bus to this block.
REQ-009 SHALL have port mem_addr  output  ADDR_WIDTH  memory address being read.
REQ-010 SHALL have port mem_oe  output  1  memory output enable; memory drives data_bus on the following cycle.
REQ-011 SHALL have port data_bus  input  DATA_WIDTH  shared data bus; this block never drives it.
REQ-012 SHALL have port out_data  output  DATA_WIDTH  dumped byte.
REQ-013 SHALL have port out_valid  output  1  out_data valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts; transfer on out_valid && out_ready at a rising edge.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when a dump completes.

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, STREAM, DONE.
REQ-018 IDLE: start=1 SHALL latch base_addr into addr_reg and length into cnt; next state ISSUE if length!=0, else DONE.
REQ-019 ISSUE: SHALL drive mem_addr=addr_reg and mem_oe=1 for exactly one cycle; next state CAPTURE.
REQ-020 CAPTURE: SHALL register data_bus into out_data at the rising edge ending CAPTURE, set out_valid=1, and go to STREAM.
REQ-021 STREAM: out_valid SHALL stay 1 and out_data SHALL stay stable until out_ready=1.
REQ-022 On a STREAM handshake: cnt decrements, addr_reg increments modulo 2^ADDR_WIDTH (wrap 2^ADDR_WIDTH-1 -> 0), and out_valid clears.
REQ-023 After a STREAM handshake: next state ISSUE if the decremented cnt != 0, else DONE.
REQ-024 DONE: SHALL assert done=1 for one cycle and drop program at that edge; next state IDLE.
REQ-025 program SHALL be 1 in ISSUE, CAPTURE, STREAM and DONE, and 0 in IDLE.
REQ-026 mem_oe SHALL be 1 only in ISSUE.
REQ-027 Latency: start accepted at edge N SHALL give out_valid=1 after edge N+2; best-case throughput SHALL be one byte per 3 cycles.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 length=2^ADDR_WIDTH SHALL read every address exactly once, starting from base_addr.
REQ-030 mem_addr SHALL hold addr_reg in all states; out_data SHALL hold the last captured value outside CAPTURE.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE from any state, including mid-dump.
REQ-032 reset SHALL force program=0, mem_oe=0, out_valid=0, busy=0, done=0, out_data=0, mem_addr=0, cnt=0.
REQ-033 A dump interrupted by reset SHALL NOT resume; no done pulse SHALL be produced for it.

Verification
REQ-034 Memory {0:00,1:50,2:09}, start with base=0, length=3, out_ready=1 -> out_data 00, 50, 09 in order; one done pulse; program high from the edge after start until the DONE edge.
REQ-035 Same dump with out_ready low for 4 cycles on the second byte -> 50 held stable with out_valid=1 for the whole stall; no byte lost or duplicated.
REQ-036 base=14, length=3 -> mem_addr sequence 14, 15, 0.
REQ-037 length=0 -> busy for one cycle, done pulse, no mem_oe, no out_valid.
REQ-038 reset asserted during STREAM of byte 2 of 3 -> IDLE next edge, all outputs per REQ-032, no done; a new start then dumps correctly.
REQ-039 start pulsed while busy with base=7 -> ignored; the original address sequence continues unchanged.
